writeback_stage: RTL and testbench

//   Y86-64 pipeline write-back stage: W pipeline register plus the architectural register file.

---
 rtl/y86_pkg.sv | 56 +++++
 rtl/writeback_stage_if.sv | 28 ++
 rtl/regfile_2w2r.sv | 51 +++++
 rtl/writeback_stage.sv | 143 ++++++++++++++
 tb/tb_writeback_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and W-stage types.
// Imported by the write-back stage and its register file.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_ERROR
  } cpu_state_e;

  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } w_ctl_t;

  localparam w_ctl_t W_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    dstE:  RNONE,
    dstM:  RNONE
  };

  // Any stat code outside the defined set is reported as INS.
  function automatic logic [2:0] norm_stat(
    input logic [2:0] s
  );
    case (s)
      S_AOK, S_HLT, S_ADR: norm_stat = s;
      default:             norm_stat = S_INS;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// M-stage to W-stage bundle, including W pipeline control.
// master drives (hazard unit + M stage), slave receives (W stage).
interface writeback_stage_if #(
  parameter int WIDTH = 64
);
  logic             W_stall;
  logic             W_bubble;
  logic [2:0]       m_stat;
  logic [3:0]       M_icode;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;
  logic [WIDTH-1:0] M_valE;
  logic [WIDTH-1:0] m_valM;

  modport master (
    output W_stall, W_bubble,
    output m_stat, M_icode,
    output M_dstE, M_dstM,
    output M_valE, m_valM
  );

  modport slave (
    input W_stall, W_bubble,
    input m_stat, M_icode,
    input M_dstE, M_dstM,
    input M_valE, m_valM
  );
endinterface

// File: rtl/regfile_2w2r.sv
// Architectural register file: two write ports (M wins),
// two decode read ports plus a debug read port.
module regfile_2w2r #(
  parameter int WIDTH = 64,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we_e,
  input  logic [3:0]       i_wa_e,
  input  logic [WIDTH-1:0] i_wd_e,
  input  logic             i_we_m,
  input  logic [3:0]       i_wa_m,
  input  logic [WIDTH-1:0] i_wd_m,
  input  logic [3:0]       i_ra_a,
  input  logic [3:0]       i_ra_b,
  input  logic [3:0]       i_ra_d,
  output logic [WIDTH-1:0] o_rd_a,
  output logic [WIDTH-1:0] o_rd_b,
  output logic [WIDTH-1:0] o_rd_d
);

  logic [WIDTH-1:0] r_mem [NREG];

  // Addresses >= NREG match no entry, so such writes drop out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_we_m && i_wa_m == 4'(i))
          r_mem[i] <= i_wd_m;
        else if (i_we_e && i_wa_e == 4'(i))
          r_mem[i] <= i_wd_e;
      end
    end
  end

  always_comb begin
    o_rd_a = '0;
    o_rd_b = '0;
    o_rd_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i_ra_a == 4'(i)) o_rd_a = r_mem[i];
      if (i_ra_b == 4'(i)) o_rd_b = r_mem[i];
      if (i_ra_d == 4'(i)) o_rd_d = r_mem[i];
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: W register, register file commit,
// processor status FSM and retired-instruction counter.
module writeback_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREG  = 15,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_stage_if.slave m_in,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [WIDTH-1:0] valA_rf,
  output logic [WIDTH-1:0] valB_rf,
  output logic [3:0]       W_icode,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [WIDTH-1:0] W_valE,
  output logic [WIDTH-1:0] W_valM,
  output logic [2:0]       W_stat,
  output logic [2:0]       cpu_stat,
  output logic [CNTW-1:0]  retired,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  w_ctl_t           r_w;
  logic [WIDTH-1:0] r_valE;
  logic [WIDTH-1:0] r_valM;
  logic             r_fresh;
  cpu_state_e       r_state;
  cpu_state_e       w_state_nxt;
  logic [2:0]       r_err_stat;
  logic [2:0]       w_err_nxt;
  logic [CNTW-1:0]  r_retired;

  logic w_commit;
  logic w_we_e;
  logic w_we_m;
  logic w_count;

  assign w_commit = (r_state == ST_RUN)
                 && (r_w.stat == S_AOK);
  assign w_we_e   = w_commit && (r_w.dstE != RNONE);
  assign w_we_m   = w_commit && (r_w.dstM != RNONE);

  // r_fresh marks the first cycle an instruction sits in W,
  // so a stalled instruction is counted only once.
  assign w_count  = w_commit && r_fresh
                 && (r_w.icode != I_NOP)
                 && (r_retired != '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w     <= W_BUBBLE;
      r_valE  <= '0;
      r_valM  <= '0;
      r_fresh <= 1'b0;
    end else if (m_in.W_stall) begin
      r_fresh <= 1'b0;
    end else if (m_in.W_bubble) begin
      r_w     <= W_BUBBLE;
      r_valE  <= '0;
      r_valM  <= '0;
      r_fresh <= 1'b0;
    end else begin
      r_w.stat  <= m_in.m_stat;
      r_w.icode <= m_in.M_icode;
      r_w.dstE  <= m_in.M_dstE;
      r_w.dstM  <= m_in.M_dstM;
      r_valE    <= m_in.M_valE;
      r_valM    <= m_in.m_valM;
      r_fresh   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_err_stat <= S_AOK;
    end else begin
      r_state    <= w_state_nxt;
      r_err_stat <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err_stat;
    cpu_stat    = S_AOK;
    case (r_state)
      ST_RUN: begin
        if (r_w.stat == S_HLT) begin
          w_state_nxt = ST_HALTED;
        end else if (r_w.stat != S_AOK) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = norm_stat(r_w.stat);
        end
      end
      ST_HALTED: cpu_stat = S_HLT;
      ST_ERROR:  cpu_stat = r_err_stat;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_retired <= '0;
    else if (w_count)
      r_retired <= r_retired + CNTW'(1);
  end

  regfile_2w2r #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we_e (w_we_e),
    .i_wa_e (r_w.dstE),
    .i_wd_e (r_valE),
    .i_we_m (w_we_m),
    .i_wa_m (r_w.dstM),
    .i_wd_m (r_valM),
    .i_ra_a (srcA),
    .i_ra_b (srcB),
    .i_ra_d (dbg_sel),
    .o_rd_a (valA_rf),
    .o_rd_b (valB_rf),
    .o_rd_d (dbg_data)
  );

  assign W_stat  = r_w.stat;
  assign W_icode = r_w.icode;
  assign W_dstE  = r_w.dstE;
  assign W_dstM  = r_w.dstM;
  assign W_valE  = r_valE;
  assign W_valM  = r_valM;
  assign retired = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table,
// saturation sequence and randomized run against a model.
module tb_writeback_stage;
  import y86_pkg::*;

  localparam int WIDTH = 64;
  localparam int NREG  = 15;
  localparam int CNTW  = 6;
  localparam int RMAX  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_if #(.WIDTH(WIDTH)) mif ();

  logic [3:0]       srcA, srcB, dbg_sel;
  logic [WIDTH-1:0] valA_rf, valB_rf, dbg_data;
  logic [3:0]       W_icode, W_dstE, W_dstM;
  logic [WIDTH-1:0] W_valE, W_valM;
  logic [2:0]       W_stat, cpu_stat;
  logic [CNTW-1:0]  retired;

  writeback_stage #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .CNTW  (CNTW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_in     (mif),
    .srcA     (srcA),
    .srcB     (srcB),
    .valA_rf  (valA_rf),
    .valB_rf  (valB_rf),
    .W_icode  (W_icode),
    .W_dstE   (W_dstE),
    .W_dstM   (W_dstM),
    .W_valE   (W_valE),
    .W_valM   (W_valM),
    .W_stat   (W_stat),
    .cpu_stat (cpu_stat),
    .retired  (retired),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural view of the machine.
  logic [63:0] md_reg [NREG];
  logic [2:0]  mw_stat;
  logic [3:0]  mw_icode, mw_dstE, mw_dstM;
  logic [63:0] mw_valE, mw_valM;
  bit          md_fresh;
  logic [2:0]  md_cpu;
  int          md_ret;

  task automatic model_step();
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) md_reg[i] = '0;
      mw_stat = S_AOK; mw_icode = I_NOP;
      mw_dstE = RNONE; mw_dstM = RNONE;
      mw_valE = '0; mw_valM = '0;
      md_fresh = 0; md_cpu = S_AOK; md_ret = 0;
      return;
    end
    if (md_cpu == S_AOK) begin
      if (mw_stat == S_AOK) begin
        if (mw_dstE < NREG) md_reg[mw_dstE] = mw_valE;
        if (mw_dstM < NREG) md_reg[mw_dstM] = mw_valM;
        if (md_fresh && mw_icode != I_NOP && md_ret < RMAX)
          md_ret++;
      end else if (mw_stat == S_HLT) md_cpu = S_HLT;
      else if (mw_stat == S_ADR) md_cpu = S_ADR;
      else md_cpu = S_INS;
    end
    if (mif.W_stall) begin
      md_fresh = 0;
    end else if (mif.W_bubble) begin
      mw_stat = S_AOK; mw_icode = I_NOP;
      mw_dstE = RNONE; mw_dstM = RNONE;
      mw_valE = '0; mw_valM = '0;
      md_fresh = 0;
    end else begin
      mw_stat = mif.m_stat; mw_icode = mif.M_icode;
      mw_dstE = mif.M_dstE; mw_dstM = mif.M_dstM;
      mw_valE = mif.M_valE; mw_valM = mif.m_valM;
      md_fresh = 1;
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit bu,
                       input logic [2:0] s, input logic [3:0] ic,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm);
    rst_n = r;
    mif.W_stall = st; mif.W_bubble = bu;
    mif.m_stat = s; mif.M_icode = ic;
    mif.M_dstE = de; mif.M_dstM = dm;
    mif.M_valE = ve; mif.m_valM = vm;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r, st, bu;
    logic [2:0] s;
    logic [3:0] ic, de, dm;
    logic [63:0] ve, vm;
    logic [3:0] sel;
    logic [63:0] e_dbg;
    logic [2:0] e_cpu;
    int e_ret;
    logic [63:0] e_wve;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    bit r, bit st, bit bu, logic [2:0] s, logic [3:0] ic,
    logic [3:0] de, logic [3:0] dm, logic [63:0] ve, logic [63:0] vm,
    logic [3:0] sel, logic [63:0] ed, logic [2:0] ec, int er,
    logic [63:0] ew);
    vec_t t;
    t.r = r; t.st = st; t.bu = bu; t.s = s; t.ic = ic;
    t.de = de; t.dm = dm; t.ve = ve; t.vm = vm; t.sel = sel;
    t.e_dbg = ed; t.e_cpu = ec; t.e_ret = er; t.e_wve = ew;
    return t;
  endfunction

  initial begin
    srcA = 0; srcB = 4'hF; dbg_sel = 0;
    drive(0, 0, 0, S_AOK, I_NOP, RNONE, RNONE, 0, 0);

    tv.push_back(v(0,0,0,S_AOK,I_NOP,15,15,0,0, 0,0,S_AOK,0,0));
    tv.push_back(v(1,0,0,S_AOK,I_IRMOVQ,3,15,'h1234,0, 3,0,S_AOK,0,'h1234));
    tv.push_back(v(1,0,0,S_AOK,I_NOP,15,15,0,0, 3,'h1234,S_AOK,1,0));
    tv.push_back(v(1,0,0,S_AOK,I_POPQ,4,4,'h108,'hBEEF, 4,0,S_AOK,1,'h108));
    tv.push_back(v(1,0,0,S_AOK,I_NOP,15,15,0,0, 4,'hBEEF,S_AOK,2,0));
    tv.push_back(v(1,0,0,S_AOK,I_RRMOVQ,6,15,'h55,0, 6,0,S_AOK,2,'h55));
    tv.push_back(v(1,1,0,S_AOK,I_IRMOVQ,7,15,'h77,0, 6,'h55,S_AOK,3,'h55));
    tv.push_back(v(1,1,0,S_AOK,I_IRMOVQ,7,15,'h77,0, 7,0,S_AOK,3,'h55));
    tv.push_back(v(1,1,0,S_AOK,I_IRMOVQ,7,15,'h77,0, 6,'h55,S_AOK,3,'h55));
    tv.push_back(v(1,0,1,S_AOK,I_IRMOVQ,7,15,'h77,0, 7,0,S_AOK,3,0));
    tv.push_back(v(1,0,0,S_AOK,I_IRMOVQ,8,15,'h88,0, 8,0,S_AOK,3,'h88));
    tv.push_back(v(1,1,1,S_AOK,I_NOP,15,15,0,0, 8,'h88,S_AOK,4,'h88));
    tv.push_back(v(1,0,0,S_AOK,I_NOP,15,15,0,0, 8,'h88,S_AOK,4,0));
    tv.push_back(v(1,0,0,S_HLT,I_HALT,15,15,0,0, 2,0,S_AOK,4,0));
    tv.push_back(v(1,0,0,S_AOK,I_OPQ,2,15,7,0, 2,0,S_HLT,4,7));
    tv.push_back(v(1,0,0,S_AOK,I_NOP,15,15,0,0, 2,0,S_HLT,4,0));
    tv.push_back(v(0,0,0,S_AOK,I_NOP,15,15,0,0, 4,0,S_AOK,0,0));
    tv.push_back(v(1,0,0,S_AOK,I_IRMOVQ,5,15,'h5A5,0, 5,0,S_AOK,0,'h5A5));
    tv.push_back(v(0,0,0,S_AOK,I_NOP,15,15,0,0, 5,0,S_AOK,0,0));
    tv.push_back(v(1,0,0,S_AOK,I_NOP,15,15,0,0, 5,0,S_AOK,0,0));
    tv.push_back(v(1,0,0,S_ADR,I_MRMOVQ,15,15,0,0, 0,0,S_AOK,0,0));
    tv.push_back(v(1,0,0,S_AOK,I_NOP,15,15,0,0, 0,0,S_ADR,0,0));
    tv.push_back(v(1,0,0,S_AOK,I_IRMOVQ,0,15,'h99,0, 0,0,S_ADR,0,'h99));
    tv.push_back(v(1,0,0,S_AOK,I_NOP,15,15,0,0, 0,0,S_ADR,0,0));

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].r, tv[i].st, tv[i].bu, tv[i].s, tv[i].ic,
            tv[i].de, tv[i].dm, tv[i].ve, tv[i].vm);
      dbg_sel = tv[i].sel; srcA = tv[i].sel; srcB = 4'hF;
      tick();
      chk($sformatf("vec%0d dbg", i), dbg_data, tv[i].e_dbg);
      chk($sformatf("vec%0d valA", i), valA_rf, tv[i].e_dbg);
      chk($sformatf("vec%0d valB", i), valB_rf, 0);
      chk($sformatf("vec%0d cpu", i), cpu_stat, tv[i].e_cpu);
      chk($sformatf("vec%0d ret", i), retired, tv[i].e_ret);
      chk($sformatf("vec%0d WvalE", i), W_valE, tv[i].e_wve);
    end

    // Reset: every register reads zero.
    drive(0, 0, 0, S_AOK, I_NOP, RNONE, RNONE, 0, 0);
    tick();
    for (int r = 0; r < NREG; r++) begin
      dbg_sel = 4'(r);
      #1 chk($sformatf("rst dbg%0d", r), dbg_data, 0);
    end

    // Counter saturation.
    for (int k = 0; k < 70; k++) begin
      drive(1, 0, 0, S_AOK, I_IRMOVQ, 4'd1, RNONE, 64'(k), 0);
      tick();
    end
    drive(1, 0, 0, S_AOK, I_NOP, RNONE, RNONE, 0, 0);
    tick();
    chk("sat retired", retired, RMAX);
    srcA = 4'd1;
    #1 chk("sat valA r1", valA_rf, 69);
    srcA = 4'hF;
    #1 chk("srcA 15", valA_rf, 0);

    // Randomized run against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] s;
      int p;
      p = $urandom_range(0, 99);
      if (p < 86) s = S_AOK;
      else if (p < 90) s = S_HLT;
      else if (p < 94) s = S_ADR;
      else if (p < 97) s = S_INS;
      else begin
        int b;
        b = $urandom_range(5, 8);
        s = (b == 8) ? 3'd0 : 3'(b);
      end
      drive(($urandom_range(0, 29) != 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0),
            s, 4'($urandom_range(0, 11)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom});
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      dbg_sel = 4'($urandom_range(0, 15));
      tick();
      chk("rnd W_stat", W_stat, mw_stat);
      chk("rnd W_icode", W_icode, mw_icode);
      chk("rnd W_dstE", W_dstE, mw_dstE);
      chk("rnd W_dstM", W_dstM, mw_dstM);
      chk("rnd W_valE", W_valE, mw_valE);
      chk("rnd W_valM", W_valM, mw_valM);
      chk("rnd cpu", cpu_stat, md_cpu);
      chk("rnd ret", retired, md_ret);
      chk("rnd valA", valA_rf, (srcA < NREG) ? md_reg[srcA] : 0);
      chk("rnd valB", valB_rf, (srcB < NREG) ? md_reg[srcB] : 0);
      chk("rnd dbg", dbg_data,
          (dbg_sel < NREG) ? md_reg[dbg_sel] : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
